// File: rtl/bg_stim_check_if.sv
// Connection bundle between the stimulus/check sequencer and the basic gates block (bg).
// The sequencer owns a/b; the gates block returns its three results.
interface bg_stim_check_if;
  logic a;
  logic b;
  logic and_op;
  logic or_op;
  logic not_op;

  modport master (
    output a,
    output b,
    input  and_op,
    input  or_op,
    input  not_op
  );

  modport slave (
    input  a,
    input  b,
    output and_op,
    output or_op,
    output not_op
  );
endinterface

// File: rtl/bg_stim_check.sv
// Self-checking stimulus sequencer for the basic gates block: sweeps (a,b) through 00..11,
// holds each vector DWELL cycles, compares and/or/not against golden. Optional macro: BG_STIM_FAIL_LOG_EN.
module bg_stim_check #(
  parameter int DWELL      = 10,
  parameter int ERR_W      = 8,
  parameter int NUM_PASSES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  bg_stim_check_if.master   bg,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [ERR_W-1:0]  err_cnt_o,
  output logic [1:0]        vec_idx_o,
  output logic              fail_valid_o,
  output logic [1:0]        fail_vec_o,
  output logic [2:0]        fail_obs_o
);

  generate
    if (DWELL < 2) begin : g_bad_dwell
      $error("bg_stim_check: DWELL must be >= 2 to guarantee a settle cycle before sampling");
    end
  endgenerate

  localparam int CNT_W = (DWELL > 2) ? $clog2(DWELL - 1) : 1;
  localparam int PC_W  = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 2);
  localparam logic [PC_W-1:0]  PASS_LAST  = PC_W'(NUM_PASSES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       state_q,    state_d;
  logic [CNT_W-1:0] dwell_q,    dwell_d;
  logic [PC_W-1:0]  pass_cnt_q, pass_cnt_d;
  logic [1:0]       vec_q,      vec_d;
  logic [ERR_W-1:0] err_q,      err_d;
  logic             pass_q,     pass_d;

  logic       start_ok;
  logic       in_sample;
  logic [2:0] obs;
  logic [2:0] gold;
  logic       mismatch;

  assign start_ok  = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign in_sample = (state_q == S_SAMPLE);
  assign obs       = {bg.and_op, bg.or_op, bg.not_op};
  assign gold      = {vec_q[1] & vec_q[0], vec_q[1] | vec_q[0], ~vec_q[1]};
  assign mismatch  = (obs != gold);

  always_comb begin
    state_d    = state_q;
    dwell_d    = dwell_q;
    pass_cnt_d = pass_cnt_q;
    vec_d      = vec_q;
    err_d      = err_q;
    pass_d     = pass_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_d    = S_DRIVE;
          dwell_d    = '0;
          pass_cnt_d = '0;
          vec_d      = '0;
          err_d      = '0;
          pass_d     = 1'b0;
        end
      end

      S_DRIVE: begin
        if (dwell_q == DWELL_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          dwell_d = dwell_q + CNT_W'(1);
        end
      end

      S_SAMPLE: begin
        if (mismatch && (err_q != '1)) begin
          err_d = err_q + ERR_W'(1);
        end
        if (vec_q != 2'd3) begin
          vec_d   = vec_q + 2'd1;
          dwell_d = '0;
          state_d = S_DRIVE;
        end else if (pass_cnt_q != PASS_LAST) begin
          vec_d      = '0;
          pass_cnt_d = pass_cnt_q + PC_W'(1);
          dwell_d    = '0;
          state_d    = S_DRIVE;
        end else begin
          // pass must include the final vector's verdict, so it looks at err_d, not err_q
          state_d = S_DONE;
          pass_d  = (err_d == '0);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      dwell_q    <= '0;
      pass_cnt_q <= '0;
      vec_q      <= '0;
      err_q      <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      pass_cnt_q <= pass_cnt_d;
      vec_q      <= vec_d;
      err_q      <= err_d;
      pass_q     <= pass_d;
    end
  end

  assign bg.a      = vec_q[1];
  assign bg.b      = vec_q[0];
  assign vec_idx_o = vec_q;
  assign err_cnt_o = err_q;
  assign busy_o    = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
  assign done_o    = (state_q == S_DONE);
  assign pass_o    = pass_q;

`ifdef BG_STIM_FAIL_LOG_EN
  logic       fail_valid_q;
  logic [1:0] fail_vec_q;
  logic [2:0] fail_obs_q;

  // Only the first mismatch of a run is kept; later ones leave the capture untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      fail_obs_q   <= '0;
    end else if (start_ok) begin
      fail_valid_q <= 1'b0;
    end else if (in_sample && mismatch && !fail_valid_q) begin
      fail_valid_q <= 1'b1;
      fail_vec_q   <= vec_q;
      fail_obs_q   <= obs;
    end
  end

  assign fail_valid_o = fail_valid_q;
  assign fail_vec_o   = fail_vec_q;
  assign fail_obs_o   = fail_obs_q;
`else
  assign fail_valid_o = 1'b0;
  assign fail_vec_o   = '0;
  assign fail_obs_o   = '0;
`endif

endmodule

// File: tb/tb_bg_stim_check.sv
// Bench for bg_stim_check: two instances (default and DWELL=2/ERR_W=3/NUM_PASSES=3) driving a
// behavioural gates model with injectable stuck-at faults, checked against a sweep-level reference.
module tb_bg_stim_check;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start0, start1;
  logic [2:0] f_en;   // {and,or,not} stuck-at enables
  logic [2:0] f_val;  // stuck-at values

  bg_stim_check_if bif0();
  bg_stim_check_if bif1();

  assign bif0.and_op = f_en[2] ? f_val[2] : (bif0.a & bif0.b);
  assign bif0.or_op  = f_en[1] ? f_val[1] : (bif0.a | bif0.b);
  assign bif0.not_op = f_en[0] ? f_val[0] : ~bif0.a;
  assign bif1.and_op = f_en[2] ? f_val[2] : (bif1.a & bif1.b);
  assign bif1.or_op  = f_en[1] ? f_val[1] : (bif1.a | bif1.b);
  assign bif1.not_op = f_en[0] ? f_val[0] : ~bif1.a;

  logic       busy0, done0, pass0, fv0;
  logic [7:0] err0;
  logic [1:0] vec0, fvec0;
  logic [2:0] fobs0;
  logic       busy1, done1, pass1, fv1;
  logic [2:0] err1;
  logic [1:0] vec1, fvec1;
  logic [2:0] fobs1;

  bg_stim_check u_dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start0), .bg(bif0),
    .busy_o(busy0), .done_o(done0), .pass_o(pass0), .err_cnt_o(err0), .vec_idx_o(vec0),
    .fail_valid_o(fv0), .fail_vec_o(fvec0), .fail_obs_o(fobs0)
  );

  bg_stim_check #(.DWELL(2), .ERR_W(3), .NUM_PASSES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .bg(bif1),
    .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_cnt_o(err1), .vec_idx_o(vec1),
    .fail_valid_o(fv1), .fail_vec_o(fvec1), .fail_obs_o(fobs1)
  );

  logic        sel;
  logic        o_a, o_b, o_busy, o_done, o_pass, o_fv;
  logic [1:0]  o_vec, o_fvec;
  logic [2:0]  o_fobs;
  logic [31:0] o_err;

  always_comb begin
    o_a    = sel ? bif1.a : bif0.a;
    o_b    = sel ? bif1.b : bif0.b;
    o_busy = sel ? busy1  : busy0;
    o_done = sel ? done1  : done0;
    o_pass = sel ? pass1  : pass0;
    o_vec  = sel ? vec1   : vec0;
    o_err  = sel ? 32'(err1) : 32'(err0);
    o_fv   = sel ? fv1    : fv0;
    o_fvec = sel ? fvec1  : fvec0;
    o_fobs = sel ? fobs1  : fobs0;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  task automatic set_start(input logic s, input logic v);
    if (s) start1 = v;
    else   start0 = v;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {o_a, o_b, o_busy, o_done, o_pass, o_vec, o_fv, o_fvec, o_fobs}, 32'd0);
    check({tag, "_err"}, o_err, 32'd0);
  endtask

  // One run on instance s: expectations come from sweeping the four vectors through the gate rules.
  task automatic run(input logic s, input bit repulse, input int abort_at);
    int dw, np, emax, exp_err, total, first_v, k_done, t, ev;
    logic [2:0] gold, obs, first_obs;
    logic [1:0] v2, evb;
    dw = s ? 2 : 10;
    np = s ? 3 : 1;
    emax = s ? 7 : 255;
    exp_err = 0;
    first_v = -1;
    first_obs = '0;
    for (int p = 0; p < np; p++) begin
      for (int v = 0; v < 4; v++) begin
        v2   = 2'(v);
        gold = {v2[1] & v2[0], v2[1] | v2[0], ~v2[1]};
        obs  = (f_en & f_val) | (~f_en & gold);
        if (obs != gold) begin
          exp_err++;
          if (first_v < 0) begin
            first_v   = v;
            first_obs = obs;
          end
        end
      end
    end
    if (exp_err > emax) exp_err = emax;
    total  = 1 + 4 * np * dw;
    k_done = -1;
    sel    = s;

    set_start(s, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(s, 1'b0);
    check("accept_busy_done_pass", {o_busy, o_done, o_pass}, 32'b100);
    check("accept_err", o_err, 32'd0);

    for (int k = 1; k <= total + 4; k++) begin
      if (k > 1) begin
        @(posedge clk);
        @(negedge clk);
      end
      if (o_done) begin
        k_done = k;
        break;
      end
      t   = k - 1;
      ev  = (t / dw) % 4;
      evb = 2'(ev);
      check("vector_ab_idx", {o_a, o_b, o_vec}, {28'd0, evb[1], evb[0], evb});
      if (repulse && t == 14) set_start(s, 1'b1);
      if (repulse && t == 15) set_start(s, 1'b0);
      if (abort_at > 0 && t == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("abort_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end

    check("done_seen", 32'(o_done), 32'd1);
    check("latency", k_done, total);
    check("end_busy_done_pass", {o_busy, o_done, o_pass}, {29'd0, 1'b0, 1'b1, exp_err == 0});
    check("end_err", o_err, exp_err);
    check("end_hold_ab_idx", {o_a, o_b, o_vec}, 32'b1111);
`ifdef BG_STIM_FAIL_LOG_EN
    check("fail_valid", 32'(o_fv), (first_v >= 0) ? 32'd1 : 32'd0);
    if (first_v >= 0) begin
      check("fail_vec", 32'(o_fvec), first_v);
      check("fail_obs", 32'(o_fobs), 32'(first_obs));
    end
`else
    check("fail_tied_off", {o_fv, o_fvec, o_fobs}, 32'd0);
`endif
    @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    f_en   = '0;
    f_val  = '0;
    sel    = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset0");
    sel = 1'b1;
    #1;
    check_all_zero("reset1");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Golden default run.
    run(1'b0, 1'b0, 0);
    // and_op stuck-at-0: only vector 3 fails.
    f_en = 3'b100; f_val = 3'b000;
    run(1'b0, 1'b0, 0);
    // not_op stuck-at-1 over 3 passes: vectors 2 and 3 fail each pass.
    f_en = 3'b001; f_val = 3'b001;
    run(1'b1, 1'b0, 0);
    // or_op stuck-at-0: 9 failures saturate a 3-bit counter.
    f_en = 3'b010; f_val = 3'b000;
    run(1'b1, 1'b0, 0);
    // Restart from DONE with a clean gate model.
    f_en = '0; f_val = '0;
    run(1'b1, 1'b0, 0);
    // Start re-pulsed while busy is ignored.
    run(1'b0, 1'b1, 0);
    // Reset mid-run, then a fresh clean run.
    run(1'b0, 1'b0, 19);
    sel = 1'b0;
    #1;
    check_all_zero("after_abort");
    run(1'b0, 1'b0, 0);

    for (int i = 0; i < 8; i++) begin
      f_en  = 3'($urandom_range(0, 7));
      f_val = 3'($urandom);
      run(1'($urandom_range(0, 1)), 1'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
